// File: rtl/if_prefetch_stage.sv
// Fetch stage: owns PCF, issues imem word fetches, buffers responses in a prefetch FIFO, drives IF/ID.
// Optional build macro IF_PERF_CNT_EN adds the PerfFetchCnt / PerfDropCnt saturating counters.
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] PerfFetchCnt,
  output logic [31:0] PerfDropCnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [OW-1:0] OUT_ONE = 1;

  logic [31:0]   pcF, respPc;
  logic [OW-1:0] outstanding, dropCnt;
  logic [AW:0]   wrPtr, rdPtr, fifoCount;
  logic [31:0]   fifoInstr [FIFO_DEPTH];
  logic [31:0]   fifoPc    [FIFO_DEPTH];
  logic [31:0]   creditUsed;
  logic          fifoEmpty, grant, resp, drop, push, pop;

  // Memory handshake: imem_req/imem_addr form a request that transfers only in a cycle
  // with imem_req && imem_gnt; each transfer gets exactly one in-order imem_rvalid,
  // never in its own grant cycle.
  assign fifoCount  = wrPtr - rdPtr;
  assign fifoEmpty  = (wrPtr == rdPtr);
  assign creditUsed = 32'(fifoCount) + 32'(outstanding);
  assign imem_req   = !reset && !PCSrcE && (32'(outstanding) < MAX_OUTSTANDING)
                      && (creditUsed < FIFO_DEPTH);
  assign imem_addr  = pcF;
  assign grant      = imem_req && imem_gnt;
  assign resp       = imem_rvalid && (outstanding != '0);
  assign drop       = resp && ((dropCnt != '0) || PCSrcE);
  assign push       = resp && !drop;
  assign pop        = !FlushD && !StallD && !fifoEmpty;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF         <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
    end else begin
      outstanding <= outstanding + OW'(grant) - OW'(resp);
      if (PCSrcE) begin
        // Everything still in flight after this cycle belongs to the old path.
        pcF     <= PCTargetE;
        respPc  <= PCTargetE;
        dropCnt <= outstanding - OW'(resp);
        wrPtr   <= '0;
        rdPtr   <= '0;
      end else begin
        if (grant) pcF <= pcF + 32'd4;
        if (push) begin
          wrPtr  <= wrPtr + PTR_ONE;
          respPc <= respPc + 32'd4;
        end
        if (resp && (dropCnt != '0)) dropCnt <= dropCnt - OUT_ONE;
        if (pop) rdPtr <= rdPtr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !PCSrcE) begin
      fifoInstr[wrPtr[AW-1:0]] <= imem_rdata;
      fifoPc[wrPtr[AW-1:0]]    <= respPc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (!fifoEmpty) begin
        InstrD   <= fifoInstr[rdPtr[AW-1:0]];
        PCD      <= fifoPc[rdPtr[AW-1:0]];
        PCPlus4D <= fifoPc[rdPtr[AW-1:0]] + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        // Starved: bubble, but keep the last PC visible.
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      PerfFetchCnt <= '0;
      PerfDropCnt  <= '0;
    end else begin
      if (push && (PerfFetchCnt != '1)) PerfFetchCnt <= PerfFetchCnt + 32'd1;
      if (drop && (PerfDropCnt != '1))  PerfDropCnt  <= PerfDropCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: memory responder plus an address-tagged reference model of fetch/decode.
module tb_if_prefetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset, StallD, FlushD, PCSrcE, imem_req, imem_gnt, imem_rvalid, ValidD;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;

  int errors = 0;
  int checks = 0;

  // Memory side: data of granted, not yet returned requests.
  logic [31:0] mem_q[$];
  // Reference model: in-flight fetches tagged {stale, addr}; expected decode queue {instr, pc}.
  logic [32:0] m_out_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_pcf, m_instr, m_pcd, m_pcp4;
  logic        m_valid;
  logic        e_req, s_req;
  logic [31:0] e_addr, s_addr, nxt_pc;

  if_prefetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  task automatic drive_mem(input bit g, input bit rv);
    imem_gnt = g;
    if (rv && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
  endtask

  // One clock: sample request side before the edge, advance memory and model, return at negedge.
  task automatic step();
    logic [32:0] ent;
    logic [63:0] head;
    bit grant_m, resp_m;
    #1;
    e_req  = !reset && !PCSrcE && (m_out_q.size() < MAXO) && (exp_q.size() + m_out_q.size() < DEPTH);
    e_addr = m_pcf;
    s_req  = imem_req;
    s_addr = imem_addr;
    @(posedge clk);
    if (imem_rvalid && mem_q.size() > 0) mem_q.delete(0);
    if (s_req && imem_gnt) mem_q.push_back($urandom());
    if (reset) begin
      m_pcf = RESET_PC; m_out_q.delete(); exp_q.delete();
      m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 1'b0;
    end else begin
      grant_m = e_req && imem_gnt;
      resp_m  = imem_rvalid && (m_out_q.size() > 0);
      if (FlushD) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (!StallD) begin
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          m_instr = head[63:32]; m_pcd = head[31:0]; m_pcp4 = head[31:0] + 32'd4; m_valid = 1'b1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
      if (resp_m) begin
        ent = m_out_q.pop_front();
        if (!ent[32] && !PCSrcE) exp_q.push_back({imem_rdata, ent[31:0]});
      end
      if (PCSrcE) begin
        for (int i = 0; i < m_out_q.size(); i++) begin
          ent = m_out_q[i]; ent[32] = 1'b1; m_out_q[i] = ent;
        end
        exp_q.delete();
        m_pcf = PCTargetE;
      end else if (grant_m) begin
        m_out_q.push_back({1'b0, m_pcf});
        m_pcf = m_pcf + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    while (mem_q.size() > 0 && n < 20) begin
      drive_mem(1'b0, 1'b1); step(); n++;
    end
    checks++;
    if (mem_q.size() != 0) begin errors++; $display("FAIL drain_timeout: pending %0d want 0", mem_q.size()); end
  endtask

  task automatic test_reset();
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    drive_mem(1'b1, 1'b0);
    step(); step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", s_req); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", InstrD, NOP); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd: got %h want 0", PCD); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pcp4: got %h want 0", PCPlus4D); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ValidD); end
    reset = 1'b0;
    drive_mem(1'b0, 1'b0);
    step();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL rst_req_after: got %b want 1", s_req); end
    checks++; if (s_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h want %h", s_addr, RESET_PC); end
    nxt_pc = RESET_PC;
  endtask

  task automatic test_stream();
    int g = -1;
    bit seen = 0;
    for (int k = 0; k < 16; k++) begin
      drive_mem(1'b1, 1'b1);
      step();
      if (g < 0 && s_req && imem_gnt) g = k;
      checks++; if (s_req !== e_req) begin errors++; $display("FAIL stream_req: got %b want %b", s_req, e_req); end
      checks++; if (InstrD !== m_instr) begin errors++; $display("FAIL stream_instr: got %h want %h", InstrD, m_instr); end
      if (ValidD === 1'b1) begin
        if (!seen) begin
          seen = 1;
          checks++; if (k + 1 - g != 3) begin errors++; $display("FAIL stream_latency: got %0d want 3", k + 1 - g); end
        end
        checks++; if (PCD !== nxt_pc) begin errors++; $display("FAIL stream_pcd: got %h want %h", PCD, nxt_pc); end
        checks++; if (PCPlus4D !== nxt_pc + 32'd4) begin errors++; $display("FAIL stream_pcp4: got %h want %h", PCPlus4D, nxt_pc + 32'd4); end
        nxt_pc = nxt_pc + 32'd4;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stream_novalid: got 0 want 1"); end
  endtask

  task automatic test_no_grant();
    logic [31:0] addr0;
    addr0 = m_pcf;
    for (int k = 0; k < 10; k++) begin
      drive_mem(1'b0, 1'b1);
      step();
      checks++; if (s_addr !== addr0) begin errors++; $display("FAIL nogrant_addr: got %h want %h", s_addr, addr0); end
      checks++; if (s_req !== e_req) begin errors++; $display("FAIL nogrant_req_model: got %b want %b", s_req, e_req); end
      if (k >= 5) begin
        checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL nogrant_req: got %b want 1", s_req); end
      end
      if (ValidD === 1'b1) begin
        checks++; if (PCD !== nxt_pc) begin errors++; $display("FAIL nogrant_pcd: got %h want %h", PCD, nxt_pc); end
        nxt_pc = nxt_pc + 32'd4;
      end
    end
    checks++; if (ValidD !== 1'b0 || InstrD !== NOP) begin errors++; $display("FAIL nogrant_bubble: got %b/%h want 0/%h", ValidD, InstrD, NOP); end
  endtask

  task automatic test_stall();
    logic [31:0] h_instr, h_pcd, h_pcp4;
    logic h_valid;
    bit seen = 0;
    h_instr = m_instr; h_pcd = m_pcd; h_pcp4 = m_pcp4; h_valid = m_valid;
    StallD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_mem(1'b1, 1'b1);
      step();
      checks++; if (s_req !== e_req) begin errors++; $display("FAIL stall_req_model: got %b want %b", s_req, e_req); end
      checks++;
      if (InstrD !== h_instr || PCD !== h_pcd || PCPlus4D !== h_pcp4 || ValidD !== h_valid) begin
        errors++; $display("FAIL stall_hold: got %h/%h/%h/%b want %h/%h/%h/%b", InstrD, PCD, PCPlus4D, ValidD, h_instr, h_pcd, h_pcp4, h_valid);
      end
    end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_credit: got %b want 0", s_req); end
    StallD = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive_mem(1'b1, 1'b1);
      step();
      checks++; if (InstrD !== m_instr) begin errors++; $display("FAIL stall_instr: got %h want %h", InstrD, m_instr); end
      if (ValidD === 1'b1) begin
        seen = 1;
        checks++; if (PCD !== nxt_pc) begin errors++; $display("FAIL stall_resume_pcd: got %h want %h", PCD, nxt_pc); end
        nxt_pc = nxt_pc + 32'd4;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_novalid: got 0 want 1"); end
  endtask

  task automatic test_redirect();
    int n = 0;
    int resp_n = 0;
    logic [31:0] third = '0;
    bit seen = 0;
    drain();
    reset = 1'b1; drive_mem(1'b0, 1'b0); step(); reset = 1'b0;
    while (m_pcf != 32'h10 && n < 20) begin drive_mem(1'b1, 1'b1); step(); n++; end
    drain();
    n = 0;
    while (m_out_q.size() < 2 && n < 10) begin drive_mem(1'b1, 1'b0); step(); n++; end
    checks++; if (mem_q.size() != 2) begin errors++; $display("FAIL redir_setup: got %0d want 2", mem_q.size()); end
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
    drive_mem(1'b1, 1'b0);
    step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b want 0", s_req); end
    checks++; if (ValidD !== 1'b0 || InstrD !== NOP) begin errors++; $display("FAIL redir_bubble: got %b/%h want 0/%h", ValidD, InstrD, NOP); end
    PCSrcE = 1'b0; FlushD = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive_mem(1'b1, 1'b1);
      if (imem_rvalid) begin resp_n++; if (resp_n == 3) third = imem_rdata; end
      step();
      if (ValidD === 1'b1) begin
        checks++; if (PCD === 32'h10 || PCD === 32'h14) begin errors++; $display("FAIL redir_stale: got %h want not 10/14", PCD); end
        if (!seen) begin
          seen = 1;
          checks++; if (PCD !== 32'h100) begin errors++; $display("FAIL redir_pcd: got %h want 100", PCD); end
          checks++; if (InstrD !== third) begin errors++; $display("FAIL redir_drop2: got %h want %h", InstrD, third); end
        end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL redir_novalid: got 0 want 1"); end
  endtask

  task automatic test_redirect_rvalid();
    int n = 0;
    bit seen = 0, got = 0;
    logic [31:0] first = '0;
    drain();
    while (m_out_q.size() < 1 && n < 10) begin drive_mem(1'b1, 1'b0); step(); n++; end
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h200;
    drive_mem(1'b0, 1'b1);
    checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL redrv_setup: got %b want 1", imem_rvalid); end
    step();
    PCSrcE = 1'b0; FlushD = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive_mem(1'b1, 1'b1);
      if (imem_rvalid && !got) begin got = 1; first = imem_rdata; end
      step();
      if (ValidD === 1'b1 && !seen) begin
        seen = 1;
        checks++; if (PCD !== 32'h200) begin errors++; $display("FAIL redrv_pcd: got %h want 200", PCD); end
        checks++; if (InstrD !== first) begin errors++; $display("FAIL redrv_nodrop: got %h want %h", InstrD, first); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL redrv_novalid: got 0 want 1"); end
  endtask

  task automatic test_reset_pending();
    int n = 0;
    bit seen = 0, got = 0;
    logic [31:0] first = '0;
    drain();
    while (m_out_q.size() < 2 && n < 10) begin drive_mem(1'b1, 1'b0); step(); n++; end
    reset = 1'b1;
    drive_mem(1'b1, 1'b0);
    step();
    reset = 1'b0;
    checks++;
    if (InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
      errors++; $display("FAIL rstp_outputs: got %h/%h/%h/%b want %h/0/0/0", InstrD, PCD, PCPlus4D, ValidD, NOP);
    end
    for (int k = 0; k < 2; k++) begin
      drive_mem(1'b0, 1'b1);
      checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rstp_pending: got %b want 1", imem_rvalid); end
      step();
      checks++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin errors++; $display("FAIL rstp_req: got %b/%h want 1/%h", s_req, s_addr, RESET_PC); end
    end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rstp_ignored: got %b want 0", ValidD); end
    for (int k = 0; k < 12; k++) begin
      drive_mem(1'b1, 1'b1);
      if (imem_rvalid && !got) begin got = 1; first = imem_rdata; end
      step();
      if (ValidD === 1'b1 && !seen) begin
        seen = 1;
        checks++; if (PCD !== RESET_PC) begin errors++; $display("FAIL rstp_pcd: got %h want %h", PCD, RESET_PC); end
        checks++; if (InstrD !== first) begin errors++; $display("FAIL rstp_instr: got %h want %h", InstrD, first); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstp_novalid: got 0 want 1"); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      StallD    = ($urandom_range(0, 4) == 0);
      PCSrcE    = ($urandom_range(0, 19) == 0);
      FlushD    = PCSrcE || ($urandom_range(0, 19) == 0);
      PCTargetE = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      drive_mem($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      if (mem_q.size() == 0 && $urandom_range(0, 9) == 0) begin imem_rvalid = 1'b1; imem_rdata = $urandom(); end
      step();
      checks++; if (s_req !== e_req) begin errors++; $display("FAIL rand_req: got %b want %b", s_req, e_req); end
      checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rand_addr: got %h want %h", s_addr, e_addr); end
      checks++; if (InstrD !== m_instr) begin errors++; $display("FAIL rand_instr: got %h want %h", InstrD, m_instr); end
      checks++; if (PCD !== m_pcd) begin errors++; $display("FAIL rand_pcd: got %h want %h", PCD, m_pcd); end
      checks++; if (PCPlus4D !== m_pcp4) begin errors++; $display("FAIL rand_pcp4: got %h want %h", PCPlus4D, m_pcp4); end
      checks++; if (ValidD !== m_valid) begin errors++; $display("FAIL rand_valid: got %b want %b", ValidD, m_valid); end
    end
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_no_grant();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
